// File: rtl/pattern_match_pkg.sv
// Shared types and default geometry for the serial pattern matcher.
package pattern_match_pkg;

  localparam int unsigned PM_N = 2;
  localparam int unsigned PM_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } matcher_state_t;

  typedef struct packed {
    logic            ena;
    logic [PM_W-1:0] mask;
    logic [PM_W-1:0] value;
  } pattern_entry_t;

endpackage

// File: rtl/pattern_cmp.sv
// Single pattern entry compared against the current window under its care mask.
module pattern_cmp
  import pattern_match_pkg::*;
#(
  parameter int unsigned W = PM_W
) (
  input  logic [W-1:0] i_window,
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_mask,
  input  logic         i_ena,
  output logic         o_hit
);

  assign o_hit = i_ena & (((i_window ^ i_value) & i_mask) == '0);

endmodule

// File: rtl/serial_pattern_matcher.sv
// Serial window matcher: last W bits vs 2**N masked patterns, lowest index wins,
// registered strobe/index plus saturating match counter.
module serial_pattern_matcher
  import pattern_match_pkg::*;
#(
  parameter int unsigned N     = PM_N,
  parameter int unsigned W     = PM_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_idx,
  input  logic [W-1:0]     cfg_value,
  input  logic [W-1:0]     cfg_mask,
  input  logic             cfg_ena,
  output logic             match_en,
  output logic [N-1:0]     match_idx,
  output logic [CNT_W-1:0] match_cnt,
  output logic             filling
);

  localparam int unsigned NE  = 2**N;
  localparam int unsigned FCW = $clog2(W);
  localparam logic [FCW-1:0] LAST_FILL = FCW'(W-1);

  typedef struct packed {
    logic         ena;
    logic [W-1:0] mask;
    logic [W-1:0] value;
  } entry_t;

  matcher_state_t   r_state, w_state_nxt;
  logic [FCW-1:0]   r_fill_cnt, w_fill_cnt_nxt;
  logic [W-1:0]     r_shreg, w_shreg_nxt, w_window;
  entry_t           r_entry [NE];
  logic [NE-1:0]    w_hit;
  logic             w_cmp_en, w_any;
  logic [N-1:0]     w_idx;
  logic             r_match_en;
  logic [N-1:0]     r_match_idx;
  logic [CNT_W-1:0] r_match_cnt;

  assign w_window = {r_shreg[W-2:0], bit_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_shreg    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    w_shreg_nxt    = r_shreg;
    w_cmp_en       = 1'b0;
    if (clear) begin
      w_state_nxt    = FILL;
      w_fill_cnt_nxt = '0;
      w_shreg_nxt    = '0;
    end else if (bit_valid) begin
      w_shreg_nxt = w_window;
      case (r_state)
        FILL: begin
          // The Wth bit completes the window and is compared on the same edge.
          if (r_fill_cnt == LAST_FILL) begin
            w_state_nxt = RUN;
            w_cmp_en    = 1'b1;
          end else begin
            w_fill_cnt_nxt = r_fill_cnt + 1'b1;
          end
        end
        RUN:     w_cmp_en = 1'b1;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NE; i++) r_entry[i] <= '0;
    end else if (cfg_we) begin
      r_entry[cfg_idx] <= '{ena: cfg_ena, mask: cfg_mask, value: cfg_value};
    end
  end

  for (genvar g = 0; g < NE; g++) begin : g_cmp
    pattern_cmp #(.W(W)) u_cmp (
      .i_window (w_window),
      .i_value  (r_entry[g].value),
      .i_mask   (r_entry[g].mask),
      .i_ena    (r_entry[g].ena),
      .o_hit    (w_hit[g])
    );
  end

  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      if (w_hit[i] && !w_any) begin
        w_any = 1'b1;
        w_idx = i[N-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match_en  <= 1'b0;
      r_match_idx <= '0;
      r_match_cnt <= '0;
    end else begin
      r_match_en <= w_cmp_en & w_any;
      if (w_cmp_en & w_any) begin
        r_match_idx <= w_idx;
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
      end
    end
  end

  assign match_en  = r_match_en;
  assign match_idx = r_match_idx;
  assign match_cnt = r_match_cnt;
  assign filling   = (r_state == FILL);

endmodule
